// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory arbiter: FSM states, access size codes and grant ids.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

endpackage

// File: rtl/mem_arb_grant_sel.sv
// Grant decision between fetch and data ports; DM wins unless the fairness counter
// (built only with UNIFIED_MEM_ARB_FAIR_EN) has seen FAIR_LIMIT DM grants starve a waiting IF.
module mem_arb_grant_sel
  import mem_arb_pkg::*;
`ifdef UNIFIED_MEM_ARB_FAIR_EN
#(
  parameter int FAIR_LIMIT = 4
)
`endif
(
`ifdef UNIFIED_MEM_ARB_FAIR_EN
  input  logic clk,
  input  logic reset,
  input  logic grant_en,
`endif
  input  logic if_req,
  input  logic dm_req,
  output logic gnt_id
);

`ifdef UNIFIED_MEM_ARB_FAIR_EN
  logic [3:0] fair_cnt;
  logic       force_if;

  assign force_if = (fair_cnt >= 4'(FAIR_LIMIT));

  always_comb begin
    gnt_id = GNT_IF;
    if (dm_req && !(if_req && force_if)) gnt_id = GNT_DM;
  end

  // Counts only DM grants that made a pending fetch wait; anything else restarts the run.
  always_ff @(posedge clk) begin
    if (reset) begin
      fair_cnt <= '0;
    end else if (grant_en) begin
      if (gnt_id == GNT_IF || !if_req) fair_cnt <= '0;
      else                             fair_cnt <= fair_cnt + 4'd1;
    end
  end
`else
  always_comb begin
    gnt_id = GNT_IF;
    if (dm_req) gnt_id = GNT_DM;
  end
`endif

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory shared by the IF fetch port and the MEM load/store port (IDLE/ACCESS/RESP FSM).
// Optional fetch fairness is enabled by defining UNIFIED_MEM_ARB_FAIR_EN.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int FAIR_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_rw,
  input  logic [1:0]        dm_size,
  input  logic              dm_se,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_di,
  output logic [1:0]        mem_size,
  output logic              mem_rw,
  output logic              mem_e,
  output logic              mem_se,
  input  logic [DATA_W-1:0] mem_do
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_e     state;
  logic [3:0] lat_cnt;
  logic       gnt_q;
  logic       flushed;
  logic       if_vld_q;
  logic       gnt_id;
  logic       grant_en;

  assign grant_en = (state == ST_IDLE) && (if_req || dm_req);

  mem_arb_grant_sel
`ifdef UNIFIED_MEM_ARB_FAIR_EN
    #(.FAIR_LIMIT(FAIR_LIMIT))
`endif
  u_grant_sel (
`ifdef UNIFIED_MEM_ARB_FAIR_EN
    .clk      (clk),
    .reset    (reset),
    .grant_en (grant_en),
`endif
    .if_req   (if_req),
    .dm_req   (dm_req),
    .gnt_id   (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      lat_cnt  <= '0;
      gnt_q    <= GNT_IF;
      flushed  <= 1'b0;
      if_vld_q <= 1'b0;
      dm_valid <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
      mem_a    <= '0;
      mem_di   <= '0;
      mem_size <= '0;
      mem_rw   <= 1'b0;
      mem_e    <= 1'b0;
      mem_se   <= 1'b0;
    end else begin
      if_vld_q <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_en) begin
            gnt_q   <= gnt_id;
            flushed <= 1'b0;
            lat_cnt <= LAT_INIT;
            mem_e   <= 1'b1;
            state   <= ST_ACCESS;
            if (gnt_id == GNT_DM) begin
              mem_a    <= dm_addr;
              mem_di   <= dm_wdata;
              mem_rw   <= dm_rw;
              mem_size <= dm_size;
              mem_se   <= dm_se;
            end else begin
              mem_a    <= if_addr;
              mem_di   <= '0;
              mem_rw   <= 1'b0;
              mem_size <= SZ_WORD;
              mem_se   <= 1'b0;
            end
          end
        end
        ST_ACCESS: begin
          // A flushed fetch still runs to completion; only its response is dropped.
          if (gnt_q == GNT_IF && if_flush) flushed <= 1'b1;
          if (lat_cnt == 4'd0) begin
            mem_e <= 1'b0;
            state <= ST_RESP;
            if (gnt_q == GNT_DM) begin
              dm_valid <= 1'b1;
              dm_rdata <= mem_rw ? '0 : mem_do;
            end else if (!flushed && !if_flush) begin
              if_vld_q <= 1'b1;
              if_rdata <= mem_do;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A flush landing in the response cycle still has to cancel the fetch pulse.
  assign if_valid = if_vld_q && !if_flush;
  assign if_stall = if_req && !if_valid;
  assign dm_stall = dm_req && !dm_valid;

endmodule
